// File: rtl/periph_fabric_if.sv
// rtl/periph_fabric_if.sv - core-side and slot-side bus bundle for periph_fabric
// The fabric takes the slave view of the core bus and drives the slot bus; the master view is the core/peripheral side.
interface periph_fabric_if #(
   parameter int NUM_SLOTS = 4
);
   logic [31:0]             m_addr;
   logic [31:0]             m_wdata;
   logic [2:0]              m_flag;
   logic                    m_we;
   logic                    m_re;
   logic [31:0]             m_rdata;
   logic                    m_ready;
   logic                    m_err;

   logic [NUM_SLOTS-1:0]    s_sel;
   logic [31:0]             s_addr;
   logic [31:0]             s_wdata;
   logic [2:0]              s_flag;
   logic                    s_we;
   logic                    s_re;
   logic [NUM_SLOTS*32-1:0] s_rdata;
   logic [NUM_SLOTS-1:0]    s_ready;

   modport slave (
      input  m_addr, m_wdata, m_flag, m_we, m_re,
      output m_rdata, m_ready, m_err,
      output s_sel, s_addr, s_wdata, s_flag, s_we, s_re,
      input  s_rdata, s_ready
   );

   modport master (
      output m_addr, m_wdata, m_flag, m_we, m_re,
      input  m_rdata, m_ready, m_err,
      input  s_sel, s_addr, s_wdata, s_flag, s_we, s_re,
      output s_rdata, s_ready
   );
endinterface

// File: rtl/periph_fabric.sv
// rtl/periph_fabric.sv - one-hot slot interconnect with wait states, timeout and error responses
// Optional error statistics (err_count/err_addr) are enabled by defining PERIPH_FABRIC_STATS_EN.
module periph_fabric #(
   parameter int          NUM_SLOTS      = 4,
   parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
   parameter logic [31:0] SLOT_SPACING   = 32'h0000_1000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic           clk,
   input  logic           rst,
   periph_fabric_if.slave bus
`ifdef PERIPH_FABRIC_STATS_EN
   ,
   output logic [15:0]    err_count,
   output logic [31:0]    err_addr
`endif
);

   localparam int SHIFT = $clog2(SLOT_SPACING);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]           state;
   logic [7:0]           tmo_cnt;
   logic [NUM_SLOTS-1:0] sel_q;
   logic                 we_q;
   logic                 re_q;
   logic [31:0]          addr_q;
   logic [31:0]          wdata_q;
   logic [2:0]           flag_q;
   logic [31:0]          rdata_q;
   logic                 ready_q;
   logic                 err_q;

   // 33-bit subtraction so addresses below the window show up as a borrow, never a wrap
   logic [32:0]          rel;
   logic [31:0]          slot_idx;
   logic [31:0]          offset;
   logic                 mapped;
   logic                 req;
   logic                 req_bad;
   logic [NUM_SLOTS-1:0] sel_d;
   logic                 slot_ready;
   logic [31:0]          slot_rdata;
   logic                 tmo_hit;
   logic                 err_evt;

   assign rel      = {1'b0, bus.m_addr} - {1'b0, BASE_ADDR};
   assign slot_idx = rel[31:0] >> SHIFT;
   assign offset   = rel[31:0] & (SLOT_SPACING - 32'd1);
   assign mapped   = !rel[32] && (slot_idx < 32'(NUM_SLOTS));
   assign req      = bus.m_we | bus.m_re;
   assign req_bad  = (bus.m_we & bus.m_re) | !mapped;
   assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_comb begin
      sel_d = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         sel_d[k] = (slot_idx == 32'(k));
      end
   end

   // The registered one-hot select doubles as the return-path mux, so foreign s_ready bits are masked off
   assign slot_ready = |(bus.s_ready & sel_q);

   always_comb begin
      slot_rdata = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (sel_q[k]) begin
            slot_rdata = slot_rdata | bus.s_rdata[k*32 +: 32];
         end
      end
   end

   assign err_evt = ((state == IDLE) && req && req_bad) ||
                    ((state == ACCESS) && !slot_ready && tmo_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         tmo_cnt <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         flag_q  <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (req_bad) begin
                     state   <= RESP;
                     ready_q <= 1'b1;
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                  end else begin
                     state   <= ACCESS;
                     sel_q   <= sel_d;
                     we_q    <= bus.m_we;
                     re_q    <= bus.m_re;
                     addr_q  <= offset;
                     wdata_q <= bus.m_wdata;
                     flag_q  <= bus.m_flag;
                  end
               end
            end
            ACCESS: begin
               // A ready arriving on the last allowed cycle still completes cleanly
               if (slot_ready || tmo_hit) begin
                  state   <= RESP;
                  ready_q <= 1'b1;
                  err_q   <= !slot_ready;
                  rdata_q <= (slot_ready && re_q) ? slot_rdata : 32'd0;
                  sel_q   <= '0;
                  we_q    <= 1'b0;
                  re_q    <= 1'b0;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            RESP: begin
               state   <= IDLE;
               tmo_cnt <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.m_rdata = rdata_q;
   assign bus.m_ready = ready_q;
   assign bus.m_err   = err_q;
   assign bus.s_sel   = sel_q;
   assign bus.s_we    = we_q;
   assign bus.s_re    = re_q;
   assign bus.s_addr  = addr_q;
   assign bus.s_wdata = wdata_q;
   assign bus.s_flag  = flag_q;

`ifdef PERIPH_FABRIC_STATS_EN
   // Full request address is kept because the master may move m_addr while a slave stalls
   logic [31:0] req_addr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_addr_q <= '0;
      end else if ((state == IDLE) && req && !req_bad) begin
         req_addr_q <= bus.m_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
         err_addr  <= '0;
      end else if (err_evt) begin
         if (err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
         end
         err_addr <= (state == IDLE) ? bus.m_addr : req_addr_q;
      end
   end
`endif

endmodule

// File: tb/tb_periph_fabric.sv
// tb/tb_periph_fabric.sv - vector table plus scoreboard bench for periph_fabric
// Covers the optional statistics outputs when PERIPH_FABRIC_STATS_EN is defined.
module tb_periph_fabric;

   logic clk = 1'b0;
   logic rst = 1'b1;

   periph_fabric_if #(.NUM_SLOTS(4)) bus ();

`ifdef PERIPH_FABRIC_STATS_EN
   logic [15:0] err_count;
   logic [31:0] err_addr;
`endif

   periph_fabric #(
      .NUM_SLOTS      (4),
      .BASE_ADDR      (32'h4000_0000),
      .SLOT_SPACING   (32'h0000_1000),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef PERIPH_FABRIC_STATS_EN
      ,
      .err_count (err_count),
      .err_addr  (err_addr)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic        re;
      logic [2:0]  flag;
      int          rdy_delay;
      bit          other_rdy;
      logic [3:0]  exp_sel;
      logic [31:0] exp_saddr;
      int          exp_acc;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      logic [31:0] addr;
   } sb_t;

   vec_t vecs[10];
   sb_t  sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_err_cnt = 0;
   logic [31:0] exp_err_addr = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drop_strobes();
      bus.m_we = 1'b0;
      bus.m_re = 1'b0;
   endtask

   task automatic check_resp();
      sb_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL spurious_m_ready: got m_ready=1 expected no pending request");
      end else begin
         e = sb_q.pop_front();
         chk("m_err", 32'(bus.m_err), 32'(e.err));
         chk("m_rdata", bus.m_rdata, e.rdata);
         if (e.err) begin
            exp_err_cnt++;
            exp_err_addr = e.addr;
         end
`ifdef PERIPH_FABRIC_STATS_EN
         chk("err_count", 32'(err_count), 32'(exp_err_cnt));
         chk("err_addr", err_addr, exp_err_addr);
`endif
      end
   endtask

   task automatic run_vec(input vec_t v);
      int  acc;
      int  lat;
      bit  done;
      sb_t e;
      @(negedge clk);
      bus.s_ready = '0;
      bus.m_addr  = v.addr;
      bus.m_wdata = v.wdata;
      bus.m_flag  = v.flag;
      bus.m_we    = v.we;
      bus.m_re    = v.re;
      e.err   = v.exp_err;
      e.rdata = v.exp_rdata;
      e.addr  = v.addr;
      sb_q.push_back(e);
      acc  = 0;
      lat  = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         lat++;
         bus.s_ready = '0;
         if (bus.s_sel != '0) begin
            acc++;
            chk("s_sel", 32'(bus.s_sel), 32'(v.exp_sel));
            chk("s_addr", bus.s_addr, v.exp_saddr);
            chk("s_wdata", bus.s_wdata, v.wdata);
            chk("s_flag", 32'(bus.s_flag), 32'(v.flag));
            chk("s_we", 32'(bus.s_we), 32'(v.we));
            chk("s_re", 32'(bus.s_re), 32'(v.re));
            if (v.other_rdy) bus.s_ready = ~v.exp_sel;
            if (v.rdy_delay >= 0 && acc == v.rdy_delay + 1) bus.s_ready = bus.s_ready | v.exp_sel;
            bus.m_addr  = $urandom;
            bus.m_wdata = $urandom;
         end
         if (bus.m_ready) begin
            check_resp();
            chk("access_cycles", 32'(acc), 32'(v.exp_acc));
            chk("latency", 32'(lat), v.exp_err && v.exp_acc == 0 ? 32'd1 : 32'(v.exp_acc + 1));
            drop_strobes();
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL response_timeout: got no m_ready expected one within 40 cycles");
         drop_strobes();
         void'(sb_q.pop_back());
      end
      bus.s_ready = '0;
      @(negedge clk);
      chk("m_ready_single", 32'(bus.m_ready), 32'd0);
      chk("m_rdata_hold", bus.m_rdata, v.exp_rdata);
      chk("m_err_hold", 32'(bus.m_err), 32'(v.exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  t0;
      int  t1;
      int  pulses;
      sb_t e;

      vecs[0] = '{32'h4000_1004, 32'h0, 1'b0, 1'b1, 3'b010, 0, 1'b0, 4'b0010, 32'h4, 1, 1'b0, 32'hA5A5_0001};
      vecs[1] = '{32'h4000_3000, 32'h1234_5678, 1'b1, 1'b0, 3'b010, 5, 1'b0, 4'b1000, 32'h0, 6, 1'b0, 32'h0};
      vecs[2] = '{32'h4000_4000, 32'h0, 1'b0, 1'b1, 3'b000, 0, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 32'h0};
      vecs[3] = '{32'h3FFF_FFFC, 32'h0, 1'b0, 1'b1, 3'b000, 0, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 32'h0};
      vecs[4] = '{32'h4000_2FFC, 32'h0, 1'b0, 1'b1, 3'b100, -1, 1'b0, 4'b0100, 32'hFFC, 16, 1'b1, 32'h0};
      vecs[5] = '{32'h4000_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 3'b000, 0, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 32'h0};
      vecs[6] = '{32'h4000_0010, 32'h0, 1'b0, 1'b1, 3'b001, 15, 1'b1, 4'b0001, 32'h10, 16, 1'b0, 32'hA5A5_0000};
      vecs[7] = '{32'h4000_3ABC, 32'h0, 1'b0, 1'b1, 3'b110, 2, 1'b1, 4'b1000, 32'hABC, 3, 1'b0, 32'hA5A5_0003};
      vecs[8] = '{32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 3'b000, 0, 1'b0, 4'b0000, 32'h0, 0, 1'b1, 32'h0};
      vecs[9] = '{32'h4000_0008, 32'hCAFE_F00D, 1'b1, 1'b0, 3'b101, 1, 1'b0, 4'b0001, 32'h8, 2, 1'b0, 32'h0};

      bus.m_addr  = '0;
      bus.m_wdata = '0;
      bus.m_flag  = '0;
      bus.m_we    = 1'b0;
      bus.m_re    = 1'b0;
      bus.s_ready = '0;
      bus.s_rdata = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

      @(negedge clk);
      chk("rst_m_ready", 32'(bus.m_ready), 32'd0);
      chk("rst_m_err", 32'(bus.m_err), 32'd0);
      chk("rst_m_rdata", bus.m_rdata, 32'd0);
      chk("rst_s_sel", 32'(bus.s_sel), 32'd0);
      chk("rst_s_strobes", 32'({bus.s_we, bus.s_re}), 32'd0);
      chk("rst_s_addr", bus.s_addr, 32'd0);
      chk("rst_s_wdata", bus.s_wdata, 32'd0);
      chk("rst_s_flag", 32'(bus.s_flag), 32'd0);
`ifdef PERIPH_FABRIC_STATS_EN
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_err_addr", err_addr, 32'd0);
`endif
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i]);
      end

      // Reset pulsed while a slave stalls: select drops at once and no response follows
      @(negedge clk);
      bus.m_addr = 32'h4000_1000;
      bus.m_re   = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_in_access", 32'(bus.s_sel), 32'b0010);
      rst = 1'b1;
      drop_strobes();
      #1;
      chk("abort_s_sel", 32'(bus.s_sel), 32'd0);
      chk("abort_s_re", 32'(bus.s_re), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.m_ready || bus.s_sel != '0) pulses++;
      end
      chk("abort_no_activity", 32'(pulses), 32'd0);
      exp_err_cnt  = 0;
      exp_err_addr = 32'd0;
      run_vec(vecs[0]);

      // Back-to-back reads of slots 0 and 2 with an always-ready slave
      @(negedge clk);
      bus.m_addr = 32'h4000_0000;
      bus.m_re   = 1'b1;
      e.err = 1'b0; e.rdata = 32'hA5A5_0000; e.addr = 32'h4000_0000;
      sb_q.push_back(e);
      pulses = 0;
      t0 = 0;
      t1 = 0;
      for (int c = 0; c < 20 && pulses < 2; c++) begin
         @(negedge clk);
         bus.s_ready = bus.s_sel;
         if (bus.m_ready) begin
            check_resp();
            pulses++;
            if (pulses == 1) begin
               t0 = c;
               bus.m_addr = 32'h4000_2008;
               e.rdata = 32'hA5A5_0002; e.addr = 32'h4000_2008;
               sb_q.push_back(e);
            end else begin
               t1 = c;
               drop_strobes();
            end
         end
      end
      bus.s_ready = '0;
      chk("b2b_pulses", 32'(pulses), 32'd2);
      chk("b2b_spacing", 32'(t1 - t0), 32'd3);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
